permutation_ctrl: RTL

PERMUTATION_CTRL -- requirements
Module: permutation_ctrl

---
 rtl/permutation_ctrl.sv | 117 +++++++++++
 1 files changed

// File: rtl/permutation_ctrl.sv
// Round sequencer for a sponge permutation core: launches a pa or pb
// permutation, steps the round index up to 4'hB and pulses done_o on completion.
module permutation_ctrl #(
  parameter int unsigned ROUNDS_A = 12,
  parameter int unsigned ROUNDS_B = 6
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       mode_i,
  output logic       enable_o,
  output logic       input_mode_o,
  output logic [3:0] round_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LAST_ROUND = 4'hB;
  localparam logic [CNT_W-1:0] START_A    = CNT_W'(12 - ROUNDS_A);
  localparam logic [CNT_W-1:0] START_B    = CNT_W'(12 - ROUNDS_B);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;

  logic               r_enable;
  logic               r_input_mode;
  logic [CNT_W-1:0]   r_round;
  logic               r_busy;
  logic               r_done;

  logic               w_enable_nxt;
  logic               w_input_mode_nxt;
  logic [CNT_W-1:0]   w_round_nxt;
  logic               w_busy_nxt;
  logic               w_done_nxt;

  // State, counter and output flops; outputs are pre-decoded from the next state
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_enable     <= 1'b0;
      r_input_mode <= 1'b0;
      r_round      <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_enable     <= w_enable_nxt;
      r_input_mode <= w_input_mode_nxt;
      r_round      <= w_round_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
    end
  end

  // Next-state and next-output decode
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_enable_nxt     = 1'b0;
    w_input_mode_nxt = 1'b0;
    w_round_nxt      = '0;
    w_busy_nxt       = 1'b0;
    w_done_nxt       = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (start_i) begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = mode_i ? START_B : START_A;
        end
      end
      S_RUN: begin
        if (r_cnt == LAST_ROUND) begin
          w_state_nxt = S_DONE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase

    // First RUN cycle loads external state; later cycles feed back the register
    w_enable_nxt     = (w_state_nxt == S_RUN);
    w_input_mode_nxt = (w_state_nxt == S_RUN) && (r_state == S_RUN);
    w_round_nxt      = (w_state_nxt == S_RUN) ? w_cnt_nxt : '0;
    w_busy_nxt       = (w_state_nxt != S_IDLE);
    w_done_nxt       = (w_state_nxt == S_DONE);
  end

  assign enable_o     = r_enable;
  assign input_mode_o = r_input_mode;
  assign round_o      = r_round;
  assign busy_o       = r_busy;
  assign done_o       = r_done;

endmodule
